// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into a registered pulse of len cycles, followed by GAP forced-low cycles.
// Optional macro PULSE_STRETCHER_RETRIGGER_EN: a trigger while high reloads the pulse length.
module pulse_stretcher #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [WIDTH-1:0] len,
    output logic             level_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] GAP_LEN = WIDTH'(GAP);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic             level_nxt, done_nxt;
    logic             pend, pend_nxt;
    logic [WIDTH-1:0] plen, plen_nxt;
    logic             retrig;

    // A requested length of zero still produces one high cycle.
    function automatic logic [WIDTH-1:0] sat_len(input logic [WIDTH-1:0] l);
        return (l == '0) ? WIDTH'(1) : l;
    endfunction

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    assign retrig = trig;
`else
    assign retrig = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_out;
        done_nxt  = 1'b0;
        pend_nxt  = pend;
        plen_nxt  = plen;
        case (state)
            S_IDLE: begin
                if (trig) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = sat_len(len);
                    level_nxt = 1'b1;
                end
            end
            S_HIGH: begin
                // cnt holds the high cycles remaining, including the current one
                if (retrig) begin
                    cnt_nxt = sat_len(len);
                end else if (cnt > WIDTH'(1)) begin
                    cnt_nxt = cnt - WIDTH'(1);
                end else begin
                    level_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    cnt_nxt   = GAP_LEN;
                    state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (cnt > WIDTH'(1)) begin
                    cnt_nxt = cnt - WIDTH'(1);
                    if (trig) begin
                        pend_nxt = 1'b1;
                        plen_nxt = len;
                    end
                end else begin
                    // A trigger in the final gap cycle wins over an older captured length
                    if (trig || pend) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = sat_len(trig ? len : plen);
                        level_nxt = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                    pend_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            done      <= 1'b0;
            pend      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
            done      <= done_nxt;
            pend      <= pend_nxt;
        end
    end

    // Captured length is only meaningful while pend is set, so it needs no reset.
    always_ff @(posedge clk) begin
        plen <= plen_nxt;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (WIDTH=8, GAP=2); honours PULSE_STRETCHER_RETRIGGER_EN.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [7:0] len;
    logic       level_out, busy, done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] lv, bz, dn;

    pulse_stretcher #(.WIDTH(8), .GAP(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .len       (len),
        .level_out (level_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit i of lv/bz/dn is the output just after edge i; trig at edge i comes from tm[i].
    task automatic seq(input logic [31:0] tm, input logic [7:0] la, input logic [7:0] lb, input int n);
        lv = '0;
        bz = '0;
        dn = '0;
        for (int i = 0; i < n; i++) begin
            trig = tm[i];
            len  = (i == 0) ? la : lb;
            @(posedge clk);
            #1;
            lv[i] = level_out;
            bz[i] = busy;
            dn[i] = done;
        end
        trig = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        trig = 1'b1;
        len  = 8'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", {29'd0, level_out, busy, done}, 32'd0);
        end
        rst  = 1'b1;
        trig = 1'b0;
        #1;
        chk("post_release_idle", {29'd0, level_out, busy, done}, 32'd0);

        // First edge after release carries a trigger
        seq(32'h1, 8'd5, 8'd5, 10);
        chk("basic5_level", lv, 32'h01F);
        chk("basic5_done",  dn, 32'h020);
        chk("basic5_busy",  bz, 32'h07F);

        seq(32'h1, 8'd0, 8'd0, 4);
        chk("len0_level", lv, 32'h1);
        chk("len0_done",  dn, 32'h2);
        chk("len0_busy",  bz, 32'h7);

        seq(32'h21, 8'd3, 8'd4, 14);
        chk("gap_last_level", lv, 32'h1E7);
        chk("gap_last_done",  dn, 32'h208);
        chk("gap_last_busy",  bz, 32'h7FF);

        seq(32'h11, 8'd3, 8'd2, 10);
        chk("gap_first_level", lv, 32'h067);
        chk("gap_first_done",  dn, 32'h088);
        chk("gap_first_busy",  bz, 32'h1FF);

        seq(32'h9, 8'd6, 8'd6, 14);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        chk("retrig_level", lv, 32'h1FF);
        chk("retrig_done",  dn, 32'h200);
`else
        chk("retrig_level", lv, 32'h03F);
        chk("retrig_done",  dn, 32'h040);
`endif

        seq(32'h1, 8'd10, 8'd10, 4);
        chk("abort_pre_level", lv, 32'hF);
        rst = 1'b0;
        #1;
        chk("abort_immediate", {29'd0, level_out, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_no_done", {29'd0, level_out, busy, done}, 32'd0);
        rst = 1'b1;
        seq(32'h1, 8'd2, 8'd2, 6);
        chk("after_abort_level", lv, 32'h03);
        chk("after_abort_done",  dn, 32'h04);

        seq(32'hFFFFF, 8'd1, 8'd1, 24);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        chk("b2b_level", lv, 32'h0FFFFF);
        chk("b2b_done",  dn, 32'h100000);
`else
        chk("b2b_level", lv, 32'h49249);
        chk("b2b_done",  dn, 32'h92492);
`endif
        chk("b2b_end_idle", {29'd0, level_out, busy, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of the length input and the internal counter.
REQ-002 SHALL have parameter GAP, default 2, meaning the number of forced-low cycles after each output pulse (0 = no gap).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port trig, input, 1 bit: single-cycle trigger pulse from an edge detector, synchronous to clk.
REQ-006 SHALL have port len, input, WIDTH bits: output pulse length in cycles, sampled only in a cycle where trig is accepted.
REQ-007 SHALL have port level_out, output, 1 bit: stretched registered output level.
REQ-008 SHALL have port busy, output, 1 bit: high while in HIGH or GAP state.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking the end of each output pulse.

Function
REQ-010 SHALL implement states IDLE, HIGH and GAP; all outputs SHALL be registered.
REQ-011 IDLE: trig=1 at edge k SHALL load counter with len, enter HIGH, and set level_out=1 from edge k (visible in cycle k+1).
REQ-012 len=0 SHALL be treated as len=1; level_out SHALL stay high for exactly max(len,1) cycles.
REQ-013 HIGH: counter decrements each cycle; on its last high cycle, the next edge SHALL clear level_out, pulse done=1 for one cycle, and enter GAP (or IDLE if GAP=0).
REQ-014 GAP: level_out SHALL stay 0 for exactly GAP cycles, then return to IDLE unless a trigger is pending.
REQ-015 trig during GAP SHALL set a pending flag and capture len; further triggers during GAP SHALL overwrite the captured len, keeping one pending entry.
REQ-016 On GAP exit with pending set, SHALL enter HIGH directly with the captured len (no IDLE cycle) and clear pending.
REQ-017 trig in the final GAP cycle SHALL count as pending and launch per REQ-016.
REQ-018 trig during HIGH SHALL behave per Configuration (REQ-024/025).
REQ-019 busy SHALL be combinationally equivalent to (state != IDLE), driven from registered state.
REQ-020 Counter arithmetic SHALL be WIDTH bits unsigned with no wrap: decrement stops at the terminal count.

Reset
REQ-021 rst=0 SHALL asynchronously force state=IDLE, level_out=0, busy=0, done=0, counter=0, pending=0.
REQ-022 Reset asserted mid-pulse or mid-gap SHALL abort immediately with no done pulse; after release, the first trig SHALL behave as from IDLE.
REQ-023 trig on the first edge after reset release SHALL be accepted.

Configuration
REQ-024 With macro PULSE_STRETCHER_RETRIGGER_EN defined, trig during HIGH SHALL reload the counter with the new len (pulse extends to max(len,1) cycles after the retrigger edge), with no done pulse and no low glitch.
REQ-025 Without PULSE_STRETCHER_RETRIGGER_EN, trig during HIGH SHALL be ignored entirely (no reload, no pending), including trig on the last HIGH cycle.

Verification
REQ-026 Reset: hold rst=0 for 3 cycles with trig=1, then release -> level_out=0, busy=0, done=0 throughout reset.
REQ-027 Basic: len=5, one trig pulse from IDLE -> level_out high exactly 5 cycles, then done=1 for 1 cycle, busy high 5+2 cycles; with len=0 -> exactly 1 high cycle.
REQ-028 Gap pending: len=3, trig; then trig with len=4 in the 2nd GAP cycle -> 3 high, 2 low, 4 high, with two done pulses.
REQ-029 Retrigger: len=6, trig; trig again with len=6 three cycles later -> with macro, 9 contiguous high cycles and one done; without macro, 6 high cycles and one done.
REQ-030 Reset mid-pulse: len=10, trig, assert rst at high cycle 4 -> level_out=0 immediately, no done; after release, trig with len=2 -> 2 high cycles.
REQ-031 Back-to-back: trig every cycle for 20 cycles with len=1, GAP=2 -> output pattern repeats 1 high, 2 low.
